aes_dec_sequencer: RTL and testbench

//  Control FSM for the iterative AES-128 decryption datapath behind the Avalon AES register file.

---
 rtl/aes_dec_sequencer_if.sv | 20 ++
 rtl/aes_dec_sequencer.sv | 95 +++++++++
 tb/tb_aes_dec_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_sequencer_if.sv
// aes_dec_sequencer_if: start request and datapath control lines between the AES decrypt sequencer and its datapath.
interface aes_dec_sequencer_if;
   logic       aes_start;
   logic       keyexp_en;
   logic       state_init;
   logic       state_ld;
   logic [1:0] op_sel;
   logic [1:0] col_sel;
   logic [3:0] round_key_idx;
   logic       busy;
   logic       aes_done;
   modport master (
      input  aes_start,
      output keyexp_en, state_init, state_ld, op_sel, col_sel, round_key_idx, busy, aes_done
   );
   modport slave (
      output aes_start,
      input  keyexp_en, state_init, state_ld, op_sel, col_sel, round_key_idx, busy, aes_done
   );
endinterface

// File: rtl/aes_dec_sequencer.sv
// aes_dec_sequencer: Moore control FSM stepping an iterative AES inverse-cipher datapath through key expansion and all rounds.
module aes_dec_sequencer #(
   parameter int KEYEXP_WAIT = 12,
   parameter int NR          = 10
) (
   input logic             clk,
   input logic             rst,
   aes_dec_sequencer_if.master bus
);
   typedef enum logic [3:0] {IDLE, KEYEXP, LOAD, ARK0, ISR, ISB, ARK, IMC, DONE} state_t;
   localparam logic [7:0] WAIT_LAST = 8'(KEYEXP_WAIT - 1);
   localparam logic [3:0] NR_IDX    = 4'(NR);
   localparam logic [3:0] NR_LAST   = 4'(NR - 1);
   state_t     state, state_nx;
   logic [7:0] wcnt, wcnt_nx;
   logic [3:0] round, round_nx;
   logic [1:0] col, col_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
         round <= '0;
         col   <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
         round <= round_nx;
         col   <= col_nx;
      end
   end
   always_comb begin
      state_nx          = state;
      wcnt_nx           = wcnt;
      round_nx          = round;
      col_nx            = col;
      bus.keyexp_en     = 1'b0;
      bus.state_init    = 1'b0;
      bus.state_ld      = 1'b0;
      bus.op_sel        = 2'd0;
      bus.col_sel       = 2'd0;
      bus.round_key_idx = 4'd0;
      bus.busy          = 1'b0;
      bus.aes_done      = 1'b0;
      case (state)
         IDLE: begin
            wcnt_nx  = '0;
            state_nx = bus.aes_start ? KEYEXP : IDLE;
         end
         KEYEXP: begin
            bus.keyexp_en = 1'b1;
            bus.busy      = 1'b1;
            state_nx      = (wcnt == WAIT_LAST) ? LOAD : KEYEXP;
            wcnt_nx       = (wcnt == WAIT_LAST) ? wcnt : wcnt + 8'd1;
         end
         LOAD: begin
            bus.state_init    = 1'b1;
            bus.state_ld      = 1'b1;
            bus.round_key_idx = NR_IDX;
            bus.busy          = 1'b1;
            state_nx          = ARK0;
         end
         ARK0: begin
            bus.state_ld      = 1'b1;
            bus.round_key_idx = NR_IDX;
            bus.busy          = 1'b1;
            round_nx          = NR_LAST;
            state_nx          = ISR;
         end
         ISR, ISB, ARK: begin
            bus.state_ld      = 1'b1;
            bus.op_sel        = (state == ISR) ? 2'd1 : (state == ISB) ? 2'd2 : 2'd0;
            bus.round_key_idx = round;
            bus.busy          = 1'b1;
            col_nx            = 2'd0;
            // round 0 is the final round, which has no InvMixColumns
            state_nx          = (state == ISR) ? ISB : (state == ISB) ? ARK : (round == 4'd0) ? DONE : IMC;
         end
         IMC: begin
            bus.state_ld      = 1'b1;
            bus.op_sel        = 2'd3;
            bus.col_sel       = col;
            bus.round_key_idx = round;
            bus.busy          = 1'b1;
            col_nx            = (col == 2'd3) ? 2'd0 : col + 2'd1;
            round_nx          = (col == 2'd3) ? round - 4'd1 : round;
            state_nx          = (col == 2'd3) ? ISR : IMC;
         end
         DONE: begin
            bus.aes_done = 1'b1;
            state_nx     = bus.aes_start ? DONE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_aes_dec_sequencer.sv
// tb_aes_dec_sequencer: directed checks of cycle trace, latency and handshake, plus an inverse-cipher model driven by the trace.
module tb_aes_dec_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   aes_dec_sequencer_if ia ();
   aes_dec_sequencer_if ib ();
   aes_dec_sequencer dut_a (.clk(clk), .rst(rst), .bus(ia));
   aes_dec_sequencer #(.KEYEXP_WAIT(1), .NR(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   always #5 clk = ~clk;
   logic [12:0] obs_a, obs_b;
   assign obs_a = {ia.keyexp_en, ia.state_init, ia.state_ld, ia.op_sel, ia.col_sel, ia.round_key_idx, ia.busy, ia.aes_done};
   assign obs_b = {ib.keyexp_en, ib.state_init, ib.state_ld, ib.op_sel, ib.col_sel, ib.round_key_idx, ib.busy, ib.aes_done};
   logic [7:0]   sbox [256];
   logic [7:0]   isbox[256];
   logic [7:0]   ek   [176];
   logic [7:0]   st   [16];
   logic [127:0] ct_v = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic [127:0] pt_v = 128'h00112233445566778899aabbccddeeff;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic init_tables();
      logic [7:0] inv, s, t0, rc;
      logic [7:0] t[4];
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
      for (int i = 0; i < 16; i++) ek[i] = 8'(i);
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = ek[i - 4 + j];
         if (i % 16 == 0) begin
            t0   = t[0];
            t[0] = sbox[t[1]] ^ rc;
            t[1] = sbox[t[2]];
            t[2] = sbox[t[3]];
            t[3] = sbox[t0];
            rc   = xt(rc);
         end
         for (int j = 0; j < 4; j++) ek[i + j] = ek[i - 16 + j] ^ t[j];
      end
   endtask

   // Applies what the datapath would latch at the coming edge, as directed by dut_a's control lines.
   task automatic model_step();
      logic [7:0] tmp[16];
      logic [7:0] a0, a1, a2, a3;
      int c, k;
      if (ia.state_init) begin
         for (int i = 0; i < 16; i++) st[i] = ct_v[127 - 8*i -: 8];
      end else begin
         case (ia.op_sel)
            2'd0: begin
               k = int'(ia.round_key_idx);
               for (int i = 0; i < 16; i++) st[i] = st[i] ^ ek[16*k + i];
            end
            2'd1: begin
               tmp = st;
               for (int cc = 0; cc < 4; cc++)
                  for (int r = 0; r < 4; r++) st[4*cc + r] = tmp[4*((cc - r + 4) % 4) + r];
            end
            2'd2: for (int i = 0; i < 16; i++) st[i] = isbox[st[i]];
            default: begin
               c  = int'(ia.col_sel);
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
               st[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
               st[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
               st[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
         endcase
      end
   endtask

   function automatic logic [127:0] st_packed();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = st[i];
      return v;
   endfunction

   // Expected {keyexp,init,ld,op,col,idx,busy,done} in cycle k after START is first sampled.
   function automatic logic [12:0] exp_at(input int k, input int kw, input int nr);
      int j, m, p;
      logic [1:0] op;
      if (k <= kw) return {3'b100, 2'd0, 2'd0, 4'd0, 2'b10};
      j = k - kw;
      if (j == 1) return {3'b011, 2'd0, 2'd0, 4'(nr), 2'b10};
      if (j == 2) return {3'b001, 2'd0, 2'd0, 4'(nr), 2'b10};
      m = j - 3;
      if (m < 7*(nr - 1)) begin
         p  = m % 7;
         op = (p == 0) ? 2'd1 : (p == 1) ? 2'd2 : (p == 2) ? 2'd0 : 2'd3;
         return {3'b001, op, (p >= 3) ? 2'(p - 3) : 2'd0, 4'(nr - 1 - m/7), 2'b10};
      end
      m = m - 7*(nr - 1);
      if (m < 3) return {3'b001, (m == 0) ? 2'd1 : (m == 1) ? 2'd2 : 2'd0, 2'd0, 4'd0, 2'b10};
      return {3'b000, 2'd0, 2'd0, 4'd0, 2'b01};
   endfunction

   function automatic logic [12:0] obs(input bit sel);
      return sel ? obs_b : obs_a;
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) ib.aes_start = v;
      else ia.aes_start = v;
   endtask

   task automatic run(input bit sel, input int kw, input int nr, input int lat, input int pulses_exp,
                      input int drop_at, input int hold, input bit kat);
      int done_k, pulses;
      logic [12:0] o;
      done_k = 0;
      pulses = 0;
      set_start(sel, 1'b1);
      for (int k = 1; k <= 300 && done_k == 0; k++) begin
         step();
         o = obs(sel);
         chk($sformatf("trace%0d_c%0d", sel, k), 128'(o), 128'(exp_at(k, kw, nr)));
         if (o[10]) pulses++;
         if (kat && o[10]) model_step();
         if (o[0]) done_k = k;
         if (k == drop_at) set_start(sel, 1'b0);
      end
      chk("latency", 128'(done_k), 128'(lat));
      chk("ld_pulses", 128'(pulses), 128'(pulses_exp));
      if (drop_at == 0) begin
         repeat (hold) begin
            step();
            chk("done_hold", 128'(obs(sel)), 128'(13'h0001));
         end
         set_start(sel, 1'b0);
      end
      step();
      chk("done_exit", 128'(obs(sel)), 128'(0));
   endtask

   initial begin
      ia.aes_start = 1'b0;
      ib.aes_start = 1'b0;
      init_tables();
      for (int i = 0; i < 16; i++) st[i] = 8'h00;
      // reset dominates a held START
      ia.aes_start = 1'b1;
      repeat (2) begin
         step();
         chk("reset_a", 128'(obs_a), 128'(0));
         chk("reset_b", 128'(obs_b), 128'(0));
      end
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step();
         chk($sformatf("pre_reset_c%0d", k), 128'(obs_a), 128'(exp_at(k, 12, 10)));
      end
      chk("c40_in_imc", 128'(obs_a[9:8]), 128'(2'd3));
      rst = 1'b1;
      ia.aes_start = 1'b0;
      step();
      chk("midrun_reset", 128'(obs_a), 128'(0));
      rst = 1'b0;
      step();
      chk("idle_after_reset", 128'(obs_a), 128'(0));
      run(1'b0, 12, 10, 81, 68, 0, 5, 1'b1);
      chk("kat_plaintext", st_packed(), pt_v);
      run(1'b0, 12, 10, 81, 68, 30, 0, 1'b0);
      run(1'b1, 1, 2, 14, 12, 0, 2, 1'b0);
      run(1'b1, 1, 2, 14, 12, 5, 0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
